// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan driver.
// Segment codes are active-low and ordered {g,f,e,d,c,b,a}.
package seg_pkg;

  typedef enum logic {
    GAP = 1'b0,
    ON  = 1'b1
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Packed table: entry 0 sits in the low bits, so the list runs F down to 0.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };

  function automatic int cnt_width(input int digit_cycles, input int gap_cycles);
    int m;
    m = 2;
    if (digit_cycles > m) m = digit_cycles;
    if (gap_cycles > m) m = gap_cycles;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/hex7seg.sv
// Combinational 4-bit hex to active-low 7-segment decoder.
module hex7seg
  import seg_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[digit];

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode display driver with dead time, leading-zero
// suppression and frame-synchronous double buffering of the shown value.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DIGIT_CYCLES = 50000,
  parameter int GAP_CYCLES   = 500
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] valueIn,
  input  logic [NUM_DIGITS-1:0]   dpIn,
  input  logic                    loadIn,
  input  logic                    lzsEn,
  input  logic                    blankIn,
  output logic [6:0]              segOut,
  output logic                    dpOut,
  output logic [NUM_DIGITS-1:0]   anOut,
  output logic                    frameDone
);

  localparam int CNT_W = cnt_width(DIGIT_CYCLES, GAP_CYCLES);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] DIG_LAST = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam state_t INIT_STATE = (GAP_CYCLES == 0) ? ON : GAP;

  state_t                  state, state_nx;
  logic [IDX_W-1:0]        idx, idx_nx;
  logic [CNT_W-1:0]        cnt, cnt_nx;
  logic                    wrap;
  logic [4*NUM_DIGITS-1:0] pend_val, pend_val_nx, act_val, act_val_nx;
  logic [NUM_DIGITS-1:0]   pend_dp, pend_dp_nx, act_dp, act_dp_nx;
  logic [3:0]              digit;
  logic [6:0]              dec_seg;
  logic                    suppress;
  logic [NUM_DIGITS-1:0]   an_nx;
  logic [6:0]              seg_nx;
  logic                    dp_nx;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= INIT_STATE;
      idx       <= '0;
      cnt       <= '0;
      pend_val  <= '0;
      pend_dp   <= '0;
      act_val   <= '0;
      act_dp    <= '0;
      anOut     <= '1;
      segOut    <= SEG_BLANK;
      dpOut     <= 1'b1;
      frameDone <= 1'b0;
    end else begin
      state     <= state_nx;
      idx       <= idx_nx;
      cnt       <= cnt_nx;
      pend_val  <= pend_val_nx;
      pend_dp   <= pend_dp_nx;
      act_val   <= act_val_nx;
      act_dp    <= act_dp_nx;
      anOut     <= an_nx;
      segOut    <= seg_nx;
      dpOut     <= dp_nx;
      frameDone <= wrap;
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    cnt_nx   = cnt + 1'b1;
    wrap     = 1'b0;
    case (state)
      GAP: begin
        if (cnt == GAP_LAST) begin
          state_nx = ON;
          cnt_nx   = '0;
        end
      end
      ON: begin
        if (cnt == DIG_LAST) begin
          cnt_nx   = '0;
          state_nx = (GAP_CYCLES == 0) ? ON : GAP;
          wrap     = (idx == IDX_LAST);
          idx_nx   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end
      end
      default: begin
        state_nx = INIT_STATE;
        cnt_nx   = '0;
      end
    endcase
  end

  // A load coinciding with the wrap edge feeds active directly via pend_*_nx.
  always_comb begin
    pend_val_nx = loadIn ? valueIn : pend_val;
    pend_dp_nx  = loadIn ? dpIn : pend_dp;
    act_val_nx  = act_val;
    act_dp_nx   = act_dp;
    if (wrap) begin
      act_val_nx = pend_val_nx;
      act_dp_nx  = pend_dp_nx;
    end
  end

  assign digit = act_val_nx[{idx_nx, 2'b00} +: 4];

  hex7seg u_hex7seg (
    .digit (digit),
    .seg   (dec_seg)
  );

  // Outputs are computed from next-cycle state so they change on the entry edge.
  always_comb begin
    suppress = lzsEn && (idx_nx != '0);
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (k >= int'(idx_nx) && (act_val_nx[4*k +: 4] != 4'h0 || act_dp_nx[k]))
        suppress = 1'b0;
    end
    an_nx  = '1;
    seg_nx = SEG_BLANK;
    dp_nx  = 1'b1;
    if (state_nx == ON) begin
      if (!blankIn) an_nx[idx_nx] = 1'b0;
      if (!suppress) begin
        seg_nx = dec_seg;
        dp_nx  = ~act_dp_nx[idx_nx];
      end
    end
  end

endmodule
